// File: rtl/reg_file_param.sv
// reg_file_param: parametrised 2R1W register file with write bypass, optional zero reg and a sequential clear engine
module reg_file_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic              clr_req,
  input  logic [ADDR_W-1:0] aa,
  input  logic [ADDR_W-1:0] ba,
  input  logic [ADDR_W-1:0] da,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              rd_valid,
  output logic              busy
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic go, wr_ok;
  logic [DATA_W-1:0] ra, rb;
  assign go = state == READY && en;
  assign wr_ok = go && wr_en && !clr_req && !(ZERO_REG != 0 && da == '0);
  // bypass follows the raw write request, so a read alongside clr_req still sees d
  assign ra = (ZERO_REG != 0 && aa == '0) ? '0 : (wr_en && da == aa) ? d : mem[aa];
  assign rb = (ZERO_REG != 0 && ba == '0) ? '0 : (wr_en && da == ba) ? d : mem[ba];
  assign busy = state == CLEAR;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= CLEAR;
      clr_ptr <= '0;
      a <= '0;
      b <= '0;
      rd_valid <= 1'b0;
    end else if (state == CLEAR) begin
      clr_ptr <= clr_ptr + 1'b1;
      rd_valid <= 1'b0;
      if (&clr_ptr) state <= READY;
    end else begin
      rd_valid <= en && rd_en;
      if (en && rd_en) begin
        a <= ra;
        b <= rb;
      end
      if (clr_req) begin
        state <= CLEAR;
        clr_ptr <= '0;
      end
    end
  always_ff @(posedge clk)
    if (state == CLEAR) mem[clr_ptr] <= '0;
    else if (wr_ok) mem[da] <= d;
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: randomized scoreboard bench for reg_file_param, ZERO_REG=0 and ZERO_REG=1 side by side
module tb_reg_file_param;
  logic clk = 0, rst = 1, en = 0, rd_en = 0, wr_en = 0, clr_req = 0;
  logic [3:0] aa = 0, ba = 0, da = 0;
  logic [15:0] d = 0;
  logic [15:0] a0, b0, a1, b1;
  logic v0, v1, busy0, busy1;
  int checks = 0, failures = 0;
  logic [63:0] q[$];
  logic [63:0] held = '0;
  logic [15:0] m [16];
  int left = 0;
  always #5 clk = ~clk;

  reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .rd_en(rd_en), .wr_en(wr_en), .clr_req(clr_req),
    .aa(aa), .ba(ba), .da(da), .d(d), .a(a0), .b(b0), .rd_valid(v0), .busy(busy0));
  reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .rd_en(rd_en), .wr_en(wr_en), .clr_req(clr_req),
    .aa(aa), .ba(ba), .da(da), .d(d), .a(a1), .b(b1), .rd_valid(v1), .busy(busy1));

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every read pulse, otherwise outputs must hold
  always @(negedge clk)
    if (!rst) begin
      if (v0) begin
        if (q.size() == 0) check("unexpected_read", {a0, b0, a1, b1}, 64'hx);
        else begin
          held = q.pop_front();
          check("read_data", {a0, b0, a1, b1}, held);
        end
      end else check("hold", {a0, b0, a1, b1}, held);
    end

  task automatic zero_model();
    for (int i = 0; i < 16; i++) m[i] = '0;
    left = 16;
  endtask

  task automatic do_reset();
    rst = 1;
    {en, rd_en, wr_en, clr_req} = '0;
    #3;
    zero_model();
    held = '0;
    check("reset_data", {a0, b0, a1, b1}, 64'h0);
    check("reset_flags", {busy0, busy1, v0, v1}, 4'b1100);
    @(negedge clk);
    rst = 0;
  endtask

  // model works at the level of "array is zero once a clear starts; busy for 16 edges"
  task automatic tick(input logic e, input logic r, input logic w, input logic c,
                      input logic [3:0] xa, input logic [3:0] xb, input logic [3:0] xd,
                      input logic [15:0] xv);
    logic [15:0] ea, eb;
    logic ev;
    en = e; rd_en = r; wr_en = w; clr_req = c; aa = xa; ba = xb; da = xd; d = xv;
    ev = 0;
    if (left > 0) left--;
    else begin
      if (e && r) begin
        ea = (w && xd == xa) ? xv : m[xa];
        eb = (w && xd == xb) ? xv : m[xb];
        q.push_back({ea, eb, xa == 0 ? 16'h0 : ea, xb == 0 ? 16'h0 : eb});
        ev = 1;
      end
      if (e && w && !c) m[xd] = xv;
      if (c) zero_model();
    end
    @(posedge clk);
    #1;
    check("busy", {busy0, busy1}, {2{left > 0}});
    check("rd_valid", {v0, v1}, {2{ev}});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    do_reset();
    idle(16);
    for (int i = 0; i < 16; i++) tick(1, 1, 0, 0, 4'(i), 4'(15 - i), 0, 0);
    tick(1, 0, 1, 0, 0, 0, 4'd3, 16'hBEEF);
    tick(1, 1, 0, 0, 4'd3, 4'd4, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 1, 1, 0, 4'd5, 4'd5, 4'd5, 16'h1234);
    tick(1, 0, 1, 0, 0, 0, 4'd0, 16'hFFFF);
    tick(1, 1, 0, 0, 4'd0, 4'd5, 0, 0);
    tick(1, 1, 1, 0, 4'd0, 4'd0, 4'd0, 16'hA5A5);
    for (int i = 1; i < 16; i++) tick(1, 0, 1, 0, 0, 0, 4'(i), 16'(i * 16'h1111));
    tick(1, 1, 0, 0, 4'd7, 4'd15, 0, 0);
    tick(1, 0, 1, 1, 0, 0, 4'd2, 16'h7777);
    idle(6);
    tick(1, 1, 1, 1, 4'd2, 4'd3, 4'd2, 16'h5555);
    idle(9);
    for (int i = 0; i < 16; i++) tick(1, 1, 0, 0, 4'(i), 4'(i ^ 1), 0, 0);
    tick(1, 0, 1, 0, 0, 0, 4'd9, 16'hCAFE);
    tick(0, 1, 1, 0, 4'd9, 4'd1, 4'd9, 16'hDEAD);
    tick(0, 0, 1, 0, 0, 0, 4'd1, 16'hDEAD);
    tick(1, 1, 0, 0, 4'd9, 4'd1, 0, 0);
    tick(1, 0, 0, 1, 0, 0, 0, 0);
    idle(9);
    do_reset();
    idle(16);
    tick(1, 1, 0, 0, 4'd9, 4'd3, 0, 0);
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 7) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
           $urandom_range(0, 39) == 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 16'($urandom));
    idle(20);
    check("queue_drained", 64'(q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the team's 16x16 register file.
- Generalises data width and depth, with two registered read ports and one write port.
- Adds same-cycle write-to-read bypass, an optional hardwired-zero register 0, and a sequential clear engine. The engine zeroes the array one entry per cycle after reset or on request, and signals progress on `busy`.
- Sits between the datapath ALU/writeback and operand fetch in the processor.

Parameters:
- DATA_W, 16, width of each register and of the d/a/b buses
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 0, when 1 register 0 always reads 0 and writes to it are discarded

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- en  in  1  global enable for read/write operations (clear engine ignores it)
- rd_en  in  1  read request for both A and B ports
- wr_en  in  1  write request
- clr_req  in  1  single-cycle request to zero the whole array
- aa  in  ADDR_W  read address, port A
- ba  in  ADDR_W  read address, port B
- da  in  ADDR_W  write address
- d  in  DATA_W  write data
- a  out  DATA_W  registered read data, port A
- b  out  DATA_W  registered read data, port B
- rd_valid  out  1  one-cycle pulse: a/b updated by the previous cycle's read
- busy  out  1  high while the clear engine is running

Behaviour:
- States: CLEAR, READY. State is held in registers asynchronously reset by rst.
- rst high (asynchronous): state=CLEAR, clr_ptr=0, a=0, b=0, rd_valid=0, busy=1.
  - Array contents are not reset asynchronously; they are zeroed by CLEAR.
- CLEAR, each clk edge:
  - Write mem[clr_ptr]=0, then clr_ptr++.
  - When clr_ptr==DEPTH-1 is written, next state is READY and busy falls on that same edge.
  - busy is therefore high for exactly DEPTH rising edges after rst falls.
  - rd_en, wr_en and clr_req are ignored; a and b hold; rd_valid=0.
- rst asserted mid-clear: clear restarts from entry 0.
- READY with en=1:
  - rd_en=1: on the next edge a<=read(aa), b<=read(ba), rd_valid<=1. Latency is 1 cycle.
  - rd_en=0: a and b hold; rd_valid<=0.
  - wr_en=1: mem[da]<=d on the edge.
  - Bypass: if rd_en and wr_en are both 1 and aa==da (or ba==da), the matching output gets d, not the old contents.
  - ZERO_REG=1: a read of address 0 returns 0, a write to address 0 is dropped, and no bypass applies to address 0.
- READY with en=0: no read, no write, a and b hold, rd_valid<=0.
- clr_req in READY (independent of en):
  - Next state is CLEAR with clr_ptr=0 and busy=1 on the following edge.
  - A wr_en in the same cycle is discarded.
  - A rd_en in the same cycle is still performed normally, with the bypass rules above.
- clr_req while already in CLEAR: ignored; the clear does not restart.
- Widths: addresses are always in range (DEPTH = 2**ADDR_W), so no wrap logic is needed beyond clr_ptr terminating at DEPTH-1.

Test Plan:
- Reset, then release rst -> busy high for 16 edges then low; a=b=0; every read of addresses 0..15 returns 0.
- READY: write d=16'hBEEF to da=3, next cycle read aa=3, ba=4 -> a=BEEF, b=0000, rd_valid pulses for 1 cycle.
- Same-cycle wr_en da=5 d=16'h1234 with rd_en aa=5 ba=5 -> a=b=1234 on the next edge; old contents never appear.
- ZERO_REG=1: write 16'hFFFF to da=0, then read aa=0 -> a=0000; with ZERO_REG=0 the same sequence gives a=FFFF.
- Fill regs 1..15 with nonzero values, pulse clr_req with wr_en da=2 d=16'h7777 -> write is dropped, busy high 16 cycles, then all reads return 0; a second clr_req mid-clear does not extend busy.
- Assert rst during CLEAR at entry 9, and separately with en=0 issue rd_en/wr_en -> clear restarts (busy for a full 16 edges after release); with en=0, a/b hold and the array is unchanged.
